// File: rtl/sweep_ctrl_if.sv
// Bundles the sweep controller's control inputs, sweep bounds, counter
// feedback and counter drive outputs. The controller connects through the
// slave modport; the side that drives the controls uses the master modport.
interface sweep_ctrl_if #(
    parameter int N = 4
);
    logic         start;
    logic         stop;
    logic         pause;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [7:0]   passes;
    logic [N-1:0] q;

    logic         en_b;
    logic         load_b;
    logic         up;
    logic [N-1:0] load_in;
    logic         busy;
    logic         done;
    logic         err;

    modport slave (
        input  start, stop, pause, lo, hi, passes, q,
        output en_b, load_b, up, load_in, busy, done, err
    );

    modport master (
        output start, stop, pause, lo, hi, passes, q,
        input  en_b, load_b, up, load_in, busy, done, err
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Sweep controller for an external up/down counter: loads lo, ramps up to hi
// and back down to lo for a programmed number of round trips (0 = run until
// stopped). Aborts on stop or on counter feedback outside [lo, hi].
//
// state  | meaning
// IDLE   | waiting for start; bounds and pass count are sampled here
// LOAD   | counter is loaded with lo
// UP     | counter incrementing toward hi
// DOWN   | counter decrementing toward lo
// DONE   | one-cycle completion pulse, counter held at lo
module sweep_ctrl #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        reset,
    sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [N-1:0] r_lo;
    logic [N-1:0] r_hi;
    logic [7:0]   r_passes;
    logic [7:0]   r_pass_cnt;
    logic         r_err;

    logic [N-1:0] w_hi_m1;
    logic [N-1:0] w_lo_p1;
    logic         w_sweeping;
    logic         w_range_bad;
    logic         w_counting;

    // Turn points; hi > lo is guaranteed once a sweep is accepted, so neither wraps.
    assign w_hi_m1     = r_hi - ONE;
    assign w_lo_p1     = r_lo + ONE;
    assign w_sweeping  = (r_state == S_UP) || (r_state == S_DOWN);
    assign w_range_bad = w_sweeping && ((bus.q < r_lo) || (bus.q > r_hi));
    assign w_counting  = (r_state == S_LOAD) || w_sweeping;

    // Counter drive is decoded straight from state so pause gates the enable immediately.
    assign bus.en_b    = !(w_counting && !bus.pause);
    assign bus.load_b  = (r_state != S_LOAD);
    assign bus.up      = (r_state == S_UP);
    assign bus.load_in = r_lo;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.err     = r_err;

    // Sequencer: stop beats a range fault, which beats pause, which beats normal stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lo       <= '0;
            r_hi       <= '0;
            r_passes   <= '0;
            r_pass_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.stop && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
            end else if (w_range_bad) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else if (!bus.pause) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (bus.hi > bus.lo) begin
                                r_lo       <= bus.lo;
                                r_hi       <= bus.hi;
                                r_passes   <= bus.passes;
                                r_pass_cnt <= bus.passes;
                                r_state    <= S_LOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: r_state <= S_UP;
                    S_UP: begin
                        if (bus.q == w_hi_m1) r_state <= S_DOWN;
                    end
                    S_DOWN: begin
                        if (bus.q == w_lo_p1) begin
                            if ((r_passes != 8'd0) && (r_pass_cnt == 8'd1)) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_UP;
                                if (r_passes != 8'd0) r_pass_cnt <= r_pass_cnt - 8'd1;
                            end
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a behavioural up/down counter closes the loop, and
// each sweep is predicted as a list of per-cycle expectations built from the
// bounds and pass count alone (load, ramp up, ramp down, done, idle).
module tb_sweep_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] q_m = 4'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'd0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit       busy;
        bit       en_b;
        bit       load_b;
        bit       up;
        bit       done;
        logic [3:0] q;
        bit       qchk;
    } rec_t;

    rec_t exp_q[$];

    sweep_ctrl_if #(.N(4)) bus ();

    sweep_ctrl #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream counter: load, step or hold; force_en lets the bench inject a bad value.
    always @(posedge clk) begin
        if (force_en)         q_m <= force_val;
        else if (!bus.en_b)   q_m <= bus.load_b ? (bus.up ? q_m + 4'd1 : q_m - 4'd1) : bus.load_in;
    end
    assign bus.q = q_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit b, input bit e, input bit l, input bit u, input bit d,
                        input int qv, input bit qc);
        rec_t r;
        r.busy = b; r.en_b = e; r.load_b = l; r.up = u; r.done = d;
        r.q = qv[3:0]; r.qchk = qc;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep: predict, start, then walk the prediction cycle by cycle.
    task automatic do_sweep(input int lo_v, input int hi_v, input int passes_v,
                            input int pause_q, input int pause_len, input bit rnd,
                            input int stop_ret, output int maxq);
        int rounds, pause_left, rets, budget;
        bit triggered, p;
        rec_t h;
        exp_q.delete();
        rounds = (passes_v == 0) ? 4 : passes_v;
        push(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < rounds; k++) begin
            for (int v = lo_v; v < hi_v; v++) push(1, 0, 1, 1, 0, v, 1);
            for (int v = hi_v; v > lo_v; v--) push(1, 0, 1, 0, 0, v, 1);
        end
        if (passes_v != 0) begin
            push(1, 1, 1, 0, 1, lo_v, 1);
            push(0, 1, 1, 0, 0, lo_v, 1);
        end
        bus.lo = lo_v[3:0]; bus.hi = hi_v[3:0]; bus.passes = passes_v[7:0]; bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.lo     = 4'($urandom);
        bus.hi     = 4'($urandom);
        bus.passes = 8'($urandom);
        pause_left = 0; triggered = 0; rets = 0; budget = 0; maxq = 0;
        while (exp_q.size() > 0 && budget < 600) begin
            h = exp_q[0];
            p = 1'b0;
            if (pause_left > 0) p = 1'b1;
            else if (!triggered && pause_q >= 0 && h.up && h.q == pause_q[3:0]) begin
                triggered = 1'b1; pause_left = pause_len; p = 1'b1;
            end else if (rnd && h.busy && !h.done && $urandom_range(0, 4) == 0) p = 1'b1;
            bus.pause = p;
            bus.start = (rnd && h.busy && !h.done) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk("ctl", {26'd0, bus.busy, bus.en_b, bus.load_b, bus.up, bus.done, bus.err},
                {26'd0, h.busy, h.en_b | p, h.load_b, h.up, h.done, 1'b0});
            if (h.qchk) begin
                chk("q", q_m, h.q);
                if (int'(q_m) > maxq) maxq = int'(q_m);
            end
            chk("load_in", bus.load_in, lo_v[3:0]);
            if (stop_ret > 0 && h.busy && !h.up && !p && h.q == 4'(lo_v + 1)) begin
                rets++;
                if (rets == stop_ret) bus.stop = 1'b1;
            end
            tick();
            if (pause_left > 0) pause_left--;
            if (!p) void'(exp_q.pop_front());
            if (bus.stop) begin
                bus.stop = 1'b0;
                bus.start = 1'b0;
                chk("stop_idle", {26'd0, bus.busy, bus.en_b, bus.load_b, bus.up, bus.done, bus.err},
                    {26'd0, 6'b011000});
                exp_q.delete();
            end
            budget++;
        end
        bus.pause = 1'b0;
        bus.start = 1'b0;
        chk("budget", (budget < 600), 1);
    endtask

    initial begin
        int mq, lo_r, hi_r;
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        bus.lo = 0; bus.hi = 0; bus.passes = 0;

        // Reset state.
        tick(); tick();
        chk("rst_out", {bus.en_b, bus.load_b, bus.up, bus.load_in, bus.busy, bus.done, bus.err},
            {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        tick();

        // Single pass 2..5..2.
        do_sweep(2, 5, 1, -1, 0, 0, 0, mq);
        // Same sweep, paused three cycles at q=4 on the way up.
        do_sweep(2, 5, 1, 4, 3, 0, 0, mq);

        // Rejected starts: hi == lo, then hi < lo.
        bus.lo = 4'd7; bus.hi = 4'd7; bus.passes = 8'd1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        chk("rej1_err", {bus.err, bus.busy, bus.en_b}, 3'b101);
        tick();
        chk("rej1_clr", {bus.err, bus.busy, bus.en_b}, 3'b001);
        bus.lo = 4'd9; bus.hi = 4'd3; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        chk("rej2_err", {bus.err, bus.busy, bus.en_b}, 3'b101);
        tick();
        chk("rej2_clr", {bus.err, bus.busy, bus.en_b}, 3'b001);

        // Continuous mode, full range, stopped on the third return to q=1.
        do_sweep(0, 15, 0, -1, 0, 0, 3, mq);
        chk("cont_span", mq, 15);

        // Minimum span, two passes: 3,4,3,4,3 then done.
        do_sweep(3, 4, 2, -1, 0, 0, 0, mq);

        // Range fault: counter jumps to 12 while sweeping 2..5.
        bus.lo = 4'd2; bus.hi = 4'd5; bus.passes = 8'd1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(); tick();
        force_en = 1'b1; force_val = 4'd12;
        tick();
        force_en = 1'b0;
        chk("flt_q", q_m, 4'd12);
        chk("flt_pre", {bus.busy, bus.err}, 2'b10);
        tick();
        chk("flt_err", {bus.busy, bus.err, bus.en_b, bus.done}, 4'b0110);
        tick();
        chk("flt_clr", {bus.busy, bus.err}, 2'b00);

        // Reset mid-sweep.
        bus.lo = 4'd1; bus.hi = 4'd9; bus.passes = 8'd2; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        repeat (5) tick();
        chk("mid_busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("mid_rst", {bus.en_b, bus.load_b, bus.up, bus.load_in, bus.busy, bus.done, bus.err},
            {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        tick();
        chk("mid_after", {bus.busy, bus.done, bus.err}, 3'b000);

        // Randomized sweeps with random pauses and stray starts.
        for (int i = 0; i < 5; i++) begin
            lo_r = $urandom_range(0, 13);
            hi_r = $urandom_range(lo_r + 1, 15);
            do_sweep(lo_r, hi_r, $urandom_range(1, 3), -1, 0, 1, 0, mq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter N, default 4: width of the counter value, bounds and load value.
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
REQ-005 stop  in  1  abort request; returns to IDLE the next cycle.
REQ-006 pause  in  1  while high, the counter is held and the FSM is frozen.
REQ-007 lo  in  N  lower sweep bound; latched on an accepted start.
REQ-008 hi  in  N  upper sweep bound; latched on an accepted start.
REQ-009 passes  in  8  number of lo->hi->lo round trips; latched on an accepted start; 0 means continuous.
REQ-010 q  in  N  counter value fed back from the downstream up/down counter.
REQ-011 en_b  out  1  active-low counter enable.
REQ-012 load_b  out  1  active-low counter load.
REQ-013 up  out  1  counter direction; 1 means increment.
REQ-014 load_in  out  N  counter load value; always equals the latched lo.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 err  out  1  one-cycle pulse on a rejected start or an out-of-range q.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, UP, DOWN and DONE, held in a register.
REQ-019 Downstream counter contract: on a rising edge with en_b=0, load_b=0 the counter takes load_in; with en_b=0, load_b=1 it steps by ±1 per up; with en_b=1 it holds.
REQ-020 Outputs SHALL be combinational from state and pause:
- en_b=0 only in LOAD, UP or DOWN with pause=0; otherwise 1.
- load_b=0 only in LOAD.
- up=1 only in UP.
REQ-021 IDLE, start=1: if hi > lo, latch lo/hi/passes, load the pass counter and go to LOAD; otherwise stay in IDLE and pulse err.
REQ-022 LOAD, pause=0: go to UP; counter now holds lo.
REQ-023 UP, pause=0: when q == hi-1, go to DOWN; the counter reaches hi on the same edge, so q never exceeds hi.
REQ-024 DOWN, pause=0, q == lo+1 (end of a round trip):
- passes != 0 and pass counter == 1: go to DONE.
- otherwise: go to UP and decrement the pass counter, except in continuous mode.
REQ-025 DONE: done=1 and en_b=1 for one cycle, then go to IDLE; q equals lo on exit.
REQ-026 In UP or DOWN, q < lo or q > hi SHALL force IDLE and pulse err on the next cycle; this check is active even while paused.
REQ-027 Priority, highest first: reset, stop, range fault, pause, normal transitions.
- stop in any non-IDLE state goes to IDLE without a done pulse.
- stop in IDLE has no effect.
REQ-028 start outside IDLE SHALL be ignored; lo/hi/passes changes outside an accepted start SHALL have no effect.
REQ-029 hi == lo+1 SHALL alternate UP and DOWN every cycle, and q SHALL toggle lo/hi.
REQ-030 Pass counter SHALL be 8 bits; in continuous mode (passes=0) it is never decremented and the sweep runs until stop.
REQ-031 Comparisons SHALL be unsigned N-bit; hi-1 and lo+1 cannot wrap because hi > lo.

Reset
REQ-032 reset=1 at a rising edge SHALL force:
- state IDLE; latched lo, hi and passes = 0; pass counter = 0.
- outputs en_b=1, load_b=1, up=0, load_in=0, busy=0, done=0, err=0.
REQ-033 Reset mid-sweep SHALL abandon the sweep with no done or err pulse; the counter value is left as is.

Verification
REQ-034 Bench model: the bench SHALL connect a behavioural counter model per REQ-019 and check every cycle.
REQ-035 Single pass:
- Stimulus: N=4, lo=2, hi=5, passes=1; start pulsed in IDLE.
- Response: q = 2,3,4,5,4,3,2 on successive cycles after LOAD; done pulses once with q=2; busy low next cycle.
REQ-036 Pause:
- Stimulus: same sweep with pause high for 3 cycles while q=4 in UP.
- Response: en_b=1 and q=4 held for 3 cycles; sequence then resumes 5,4,...
REQ-037 Rejected start:
- Stimulus: lo=7, hi=7, start.
- Response: err pulses, state stays IDLE, en_b stays 1.
- Repeat with lo=9, hi=3; same response.
REQ-038 Continuous mode and stop:
- Stimulus: passes=0, lo=0, hi=15; stop asserted on the third return to q=1.
- Response: IDLE next cycle, no done pulse.
- Check: q spans 0..15 with no wrap.
REQ-039 Minimum span, fault and reset:
- Stimulus 1: lo=3, hi=4, passes=2.
- Response 1: q = 3,4,3,4,3, then done.
- Stimulus 2: force the counter model's q to 12 while hi=5.
- Response 2: err pulses and state goes to IDLE.
- Stimulus 3: reset mid-sweep.
- Response 3: all outputs at REQ-032 values.
